// File: rtl/pwm_meter_pkg.sv
// Shared types and default sizing for the PWM duty meter.
// Optional input synchronizer is selected with PWM_METER_SYNC_EN (see pwm_edge_sync).
package pwm_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } meter_state_t;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_TIMEOUT = 200;

endpackage

// File: rtl/pwm_edge_sync.sv
// Samples pwm_in (optionally through a 2-flop synchronizer) and flags edges.
// Macro PWM_METER_SYNC_EN: defined -> 2-flop synchronizer in front of the edge detector.
module pwm_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic level_in;
    logic s_reg;
    logic s_prev_reg;

`ifdef PWM_METER_SYNC_EN
    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], pwm_in};
        end
    end

    assign level_in = sync_reg[1];
`else
    assign level_in = pwm_in;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_reg      <= 1'b0;
            s_prev_reg <= 1'b0;
        end else begin
            s_reg      <= level_in;
            s_prev_reg <= s_reg;
        end
    end

    assign s    = s_reg;
    assign rise = s_reg & ~s_prev_reg;
    assign fall = ~s_reg & s_prev_reg;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time and period of pwm_in in clk cycles, with a valid/ready result port.
// Build option PWM_METER_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
module pwm_duty_meter
    import pwm_meter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             ovf,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             overrun,
    output logic             stuck,
    output logic             stuck_lvl
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic s;
    logic rise;
    logic fall;

    meter_state_t     state_reg, state_next;
    logic [CNT_W-1:0] hc_reg, hc_next;
    logic [CNT_W-1:0] pc_reg, pc_next;
    logic [CNT_W-1:0] tc_reg, tc_next;
    logic             done;
    logic             timeout;

    logic [CNT_W-1:0] high_res_reg;
    logic [CNT_W-1:0] period_res_reg;
    logic             ovf_res_reg;
    logic             valid_reg;
    logic             overrun_reg;
    logic             stuck_reg;
    logic             stuck_lvl_reg;
    logic             consume;

    pwm_edge_sync u_edge (
        .clk    (clk),
        .reset  (reset),
        .pwm_in (pwm_in),
        .s      (s),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            hc_reg    <= '0;
            pc_reg    <= '0;
            tc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            hc_reg    <= hc_next;
            pc_reg    <= pc_next;
            tc_reg    <= tc_next;
        end
    end

    // tc counts cycles since the last edge; it restarts at 0 on every edge.
    always_comb begin
        state_next = state_reg;
        hc_next    = hc_reg;
        pc_next    = pc_reg;
        tc_next    = tc_reg;
        done       = 1'b0;
        timeout    = 1'b0;
        case (state_reg)
            IDLE: begin
                hc_next = '0;
                pc_next = '0;
                tc_next = '0;
                if (rise) begin
                    state_next = HIGH;
                    hc_next    = CNT_ONE;
                    pc_next    = CNT_ONE;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_next = LOW;
                    pc_next    = sat_inc(pc_reg);
                    tc_next    = '0;
                end else if (tc_reg == TC_LAST) begin
                    state_next = IDLE;
                    timeout    = 1'b1;
                    hc_next    = '0;
                    pc_next    = '0;
                    tc_next    = '0;
                end else begin
                    hc_next = sat_inc(hc_reg);
                    pc_next = sat_inc(pc_reg);
                    tc_next = tc_reg + CNT_ONE;
                end
            end
            LOW: begin
                if (rise) begin
                    done       = 1'b1;
                    state_next = HIGH;
                    hc_next    = CNT_ONE;
                    pc_next    = CNT_ONE;
                    tc_next    = '0;
                end else if (tc_reg == TC_LAST) begin
                    state_next = IDLE;
                    timeout    = 1'b1;
                    hc_next    = '0;
                    pc_next    = '0;
                    tc_next    = '0;
                end else begin
                    pc_next = sat_inc(pc_reg);
                    tc_next = tc_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                hc_next    = '0;
                pc_next    = '0;
                tc_next    = '0;
            end
        endcase
    end

    assign consume = valid_reg & meas_ready;

    // A completion is only accepted when the slot is empty or being drained this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            high_res_reg   <= '0;
            period_res_reg <= '0;
            ovf_res_reg    <= 1'b0;
            valid_reg      <= 1'b0;
            overrun_reg    <= 1'b0;
            stuck_reg      <= 1'b0;
            stuck_lvl_reg  <= 1'b0;
        end else begin
            if (done && (!valid_reg || meas_ready)) begin
                high_res_reg   <= hc_reg;
                period_res_reg <= pc_reg;
                ovf_res_reg    <= (hc_reg == CNT_MAX) || (pc_reg == CNT_MAX);
                valid_reg      <= 1'b1;
            end else if (consume) begin
                valid_reg <= 1'b0;
            end

            if (consume) begin
                overrun_reg <= 1'b0;
            end else if (done && valid_reg) begin
                overrun_reg <= 1'b1;
            end

            if (timeout) begin
                stuck_reg     <= 1'b1;
                stuck_lvl_reg <= s;
            end else if (rise || fall) begin
                stuck_reg     <= 1'b0;
                stuck_lvl_reg <= 1'b0;
            end
        end
    end

    assign high_cnt   = high_res_reg;
    assign period_cnt = period_res_reg;
    assign ovf        = ovf_res_reg;
    assign meas_valid = valid_reg;
    assign overrun    = overrun_reg;
    assign stuck      = stuck_reg;
    assign stuck_lvl  = stuck_lvl_reg;

endmodule

// File: doc/pwm_duty_meter.md
PWM_DUTY_METER -- requirements
Module: pwm_duty_meter

Interface
REQ-001 Parameter CNT_W, default 8, width of all measurement counters and result fields.
REQ-002 Parameter TIMEOUT, default 200, clk cycles without a pwm_in edge before the measurement is abandoned; SHALL be <= 2^CNT_W-1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release is synchronous to clk.
REQ-005 pwm_in  input  1  PWM waveform to measure, typically the PWM generator output.
REQ-006 high_cnt  output  CNT_W  measured high time, clk cycles.
REQ-007 period_cnt  output  CNT_W  measured period, clk cycles.
REQ-008 ovf  output  1  result saturated (high or period reached 2^CNT_W-1).
REQ-009 meas_valid  output  1  result fields hold an unconsumed measurement.
REQ-010 meas_ready  input  1  consumer accepts result when meas_valid & meas_ready.
REQ-011 overrun  output  1  sticky: a completed measurement was dropped because the held result was not consumed.
REQ-012 stuck  output  1  level: pwm_in has had no edge for TIMEOUT cycles; stuck_lvl gives the level.
REQ-013 stuck_lvl  output  1  sampled pwm_in level while stuck=1, else 0.

Function
REQ-014 pwm_in SHALL pass through the edge-detect stage; s = sampled level, rise = s & !s_prev, fall = !s & s_prev.
REQ-015 FSM states: IDLE, HIGH, LOW.
REQ-016 IDLE: on rise -> HIGH, hc=1, pc=1; otherwise stay; counters hold 0.
REQ-017 HIGH: each cycle with s=1 -> hc+1, pc+1; on fall -> LOW, pc+1.
REQ-018 LOW: each cycle with s=0 -> pc+1; on rise -> complete measurement (high_cnt=hc, period_cnt=pc), then HIGH with hc=1, pc=1 (back-to-back periods, no gap).
REQ-019 Counters SHALL saturate at 2^CNT_W-1, never wrap; reaching saturation sets the ovf field of that measurement.
REQ-020 A cycle counter SHALL reset to 0 on every edge; reaching TIMEOUT in HIGH or LOW -> IDLE, stuck=1, stuck_lvl=s, partial measurement discarded; stuck clears on the next edge.
REQ-021 Completion with meas_valid=0 -> load result, meas_valid=1 next cycle.
REQ-022 Completion with meas_valid=1 and meas_ready=1 same cycle -> old result consumed, new result loaded, meas_valid stays 1.
REQ-023 Completion with meas_valid=1 and meas_ready=0 -> new result dropped, overrun=1; held result unchanged.
REQ-024 overrun SHALL clear on the cycle following a successful handshake.
REQ-025 Result fields SHALL remain stable while meas_valid=1 and meas_ready=0.
REQ-026 Latency: meas_valid asserts 1 cycle after the clk edge at which rise is detected, plus the synchronizer delay (REQ-030).
REQ-027 Duty 0% or 100% input SHALL produce no measurement, only stuck after TIMEOUT.

Reset
REQ-028 reset low: state IDLE, all counters 0, high_cnt=0, period_cnt=0, ovf=0, meas_valid=0, overrun=0, stuck=0, stuck_lvl=0, s_prev=0, synchronizer flops 0.
REQ-029 reset mid-measurement SHALL discard all partial and held results; first measurement after release needs a fresh rising edge.

Configuration
REQ-030 Macro PWM_METER_SYNC_EN: defined -> pwm_in passes a 2-flop synchronizer before edge detection (+2 cycles latency, async inputs allowed); undefined -> pwm_in sampled by the edge-detect flop only (pwm_in must be synchronous to clk), counts identical.

Structure
REQ-031 Package pwm_meter_pkg SHALL hold the FSM state type (IDLE/HIGH/LOW) and default CNT_W and TIMEOUT constants.
REQ-032 Sub-module pwm_edge_sync SHALL contain the optional synchronizer and edge detect, outputting s, rise, fall.

Verification
REQ-033 pwm_in 30 high / 70 low, repeated, meas_ready=1 -> each result high_cnt=30, period_cnt=100, ovf=0, one meas_valid pulse per period.
REQ-034 pwm_in 200 high / 100 low -> period_cnt=255, high_cnt=200, ovf=1.
REQ-035 meas_ready=0 across two 30/70 periods -> first result held, overrun=1; raise meas_ready -> handshake, overrun=0 next cycle.
REQ-036 pwm_in held high 250 cycles after a rise -> stuck=1, stuck_lvl=1 at TIMEOUT, meas_valid stays 0; next fall clears stuck.
REQ-037 reset low for 1 cycle at 50 cycles into LOW phase -> all outputs 0 immediately; next full period measures correctly.
